// File: rtl/pc_gen.sv
// Fetch PC owner: issues sequential fetch requests, applies execute-stage redirects,
// and halts fetch with a sticky error when a control transfer lands misaligned.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  input  logic        fetch_ready,
  output logic        fetch_drop,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [1:0]  ex_kind,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic        br_taken,
  output logic [31:0] link_pc,
  output logic        redirect,
  output logic        misalign,
  output logic [31:0] misalign_addr
);

  typedef enum logic [2:0] {IDLE, RUN, HOLD, DRAIN, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] pend_target, pend_nxt;
  logic        outstanding, outstanding_nxt;
  logic        misalign_nxt;
  logic [31:0] misalign_addr_nxt;
  logic [31:0] target;
  logic        take;
  logic        bad_target;
  logic        pending;

  always_comb begin
    target = ex_pc + ex_imm;
    if (ex_kind == 2'b10) target = (ex_rs1 + ex_imm) & ~32'h1;
  end

  assign take       = ex_valid && ((ex_kind == 2'b01) || (ex_kind == 2'b10) ||
                                   ((ex_kind == 2'b00) && br_taken));
  assign bad_target = (target[1:0] != 2'b00);
  assign link_pc    = ex_pc + 32'd4;

  // A request once shown must stay up until accepted, so stall only gates new ones.
  assign fetch_valid = (state == RUN) ? (outstanding || !stall)
                                      : ((state == HOLD) || (state == DRAIN));
  assign pending     = fetch_valid && !fetch_ready;
  assign redirect    = take && (state == RUN);
  assign fetch_drop  = ((state == HOLD) || (state == DRAIN)) && fetch_ready;

  always_comb begin
    state_nxt         = state;
    pc_nxt            = fetch_pc;
    pend_nxt          = pend_target;
    outstanding_nxt   = 1'b0;
    misalign_nxt      = misalign;
    misalign_addr_nxt = misalign_addr;
    case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        outstanding_nxt = pending;
        if (take) begin
          if (bad_target) begin
            misalign_nxt      = 1'b1;
            misalign_addr_nxt = target;
            state_nxt         = pending ? DRAIN : HALT;
          end else if (pending) begin
            pend_nxt  = target;
            state_nxt = HOLD;
          end else begin
            pc_nxt = target;
          end
        end else if (fetch_valid && fetch_ready) begin
          pc_nxt = fetch_pc + 32'd4;
        end
      end
      HOLD: begin
        if (fetch_ready) begin
          pc_nxt    = pend_target;
          state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (fetch_ready) state_nxt = HALT;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      pend_target   <= 32'h0;
      outstanding   <= 1'b0;
      misalign      <= 1'b0;
      misalign_addr <= 32'h0;
    end else begin
      state         <= state_nxt;
      fetch_pc      <= pc_nxt;
      pend_target   <= pend_nxt;
      outstanding   <= outstanding_nxt;
      misalign      <= misalign_nxt;
      misalign_addr <= misalign_addr_nxt;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a per-cycle reference model checked on every falling edge,
// plus hand-computed literal expectations along the stimulus sequence.
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        fetch_drop;
  logic        stall;
  logic        ex_valid;
  logic [1:0]  ex_kind;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        br_taken;
  logic [31:0] link_pc;
  logic        redirect;
  logic        misalign;
  logic [31:0] misalign_addr;

  int checks = 0;
  int errors = 0;

  pc_gen dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .fetch_drop(fetch_drop), .stall(stall),
    .ex_valid(ex_valid), .ex_kind(ex_kind), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .br_taken(br_taken),
    .link_pc(link_pc), .redirect(redirect),
    .misalign(misalign), .misalign_addr(misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: where fetch is, whether it is waiting out a stale request,
  // and whether it has given up for good.
  localparam int P_IDLE = 0, P_RUN = 1, P_WAIT = 2, P_HALT = 3;
  int          m_phase;
  logic [31:0] m_pc;
  logic        m_shown;       // previous cycle showed a request that was not taken
  logic        m_halt_after;  // the stale request being waited out ends in halt
  logic [31:0] redir_q[$];
  logic        m_mis;
  logic [31:0] m_mis_addr;

  task automatic model_reset();
    m_phase = P_IDLE; m_pc = 32'h0; m_shown = 1'b0; m_halt_after = 1'b0;
    redir_q.delete(); m_mis = 1'b0; m_mis_addr = 32'h0;
  endtask

  always @(negedge rst_n) model_reset();

  always @(negedge clk) begin
    logic        e_fv, e_acc, e_take, e_drop;
    logic [31:0] tgt;
    if (!rst_n) begin
      model_reset();
      chk("m_rst_fv", {31'b0, fetch_valid}, 32'h0);
      chk("m_rst_pc", fetch_pc, 32'h0);
      chk("m_rst_drop", {31'b0, fetch_drop}, 32'h0);
      chk("m_rst_redir", {31'b0, redirect}, 32'h0);
      chk("m_rst_mis", {31'b0, misalign}, 32'h0);
      chk("m_rst_addr", misalign_addr, 32'h0);
    end else begin
      e_fv   = (m_phase == P_WAIT) || ((m_phase == P_RUN) && (m_shown || !stall));
      e_acc  = e_fv && fetch_ready;
      tgt    = (ex_kind == 2'd2) ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
      e_take = (m_phase == P_RUN) && ex_valid &&
               (ex_kind == 2'd1 || ex_kind == 2'd2 || (ex_kind == 2'd0 && br_taken));
      e_drop = (m_phase == P_WAIT) && fetch_ready;
      chk("m_fv", {31'b0, fetch_valid}, {31'b0, e_fv});
      chk("m_pc", fetch_pc, m_pc);
      chk("m_drop", {31'b0, fetch_drop}, {31'b0, e_drop});
      chk("m_redir", {31'b0, redirect}, {31'b0, e_take});
      chk("m_link", link_pc, ex_pc + 32'd4);
      chk("m_mis", {31'b0, misalign}, {31'b0, m_mis});
      chk("m_mis_addr", misalign_addr, m_mis_addr);
      case (m_phase)
        P_IDLE: m_phase = P_RUN;
        P_RUN: begin
          if (e_take && tgt[1:0] != 2'b00) begin
            m_mis = 1'b1; m_mis_addr = tgt;
            m_halt_after = 1'b1;
            m_phase = (e_fv && !e_acc) ? P_WAIT : P_HALT;
          end else if (e_take && e_fv && !e_acc) begin
            redir_q.push_back(tgt);
            m_halt_after = 1'b0;
            m_phase = P_WAIT;
          end else if (e_take) begin
            m_pc = tgt;
          end else if (e_acc) begin
            m_pc = m_pc + 32'd4;
          end
          m_shown = e_fv && !e_acc;
        end
        P_WAIT: if (e_acc) begin
          if (m_halt_after) m_phase = P_HALT;
          else begin
            m_pc = redir_q.pop_front();
            m_phase = P_RUN;
            m_shown = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ctl(input logic v, input logic [1:0] k, input logic [31:0] pc_i,
                     input logic [31:0] imm, input logic [31:0] rs1, input logic br);
    ex_valid = v; ex_kind = k; ex_pc = pc_i; ex_imm = imm; ex_rs1 = rs1; br_taken = br;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
    ctl(1'b0, 2'd3, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("rst_fv", {31'b0, fetch_valid}, 32'h0);
    chk("rst_pc", fetch_pc, 32'h0);
    chk("rst_mis", {31'b0, misalign}, 32'h0);
    step(); rst_n = 1'b1;
    @(negedge clk); chk("idle_fv", {31'b0, fetch_valid}, 32'h0);
    @(negedge clk); chk("first_fv", {31'b0, fetch_valid}, 32'h1); chk("seq0", fetch_pc, 32'h0);
    @(negedge clk); chk("seq1", fetch_pc, 32'h4);
    @(negedge clk); chk("seq2", fetch_pc, 32'h8);

    // Taken branch backwards, then not-taken.
    step(); ctl(1'b1, 2'd0, 32'h100, 32'hFFFF_FFF0, 32'h0, 1'b1);
    @(negedge clk); chk("br_redir", {31'b0, redirect}, 32'h1); chk("br_link", link_pc, 32'h104);
    step(); ex_valid = 1'b0;
    @(negedge clk); chk("br_tgt", fetch_pc, 32'hF0);
    step(); ctl(1'b1, 2'd0, 32'h100, 32'hFFFF_FFF0, 32'h0, 1'b0);
    @(negedge clk); chk("nt_redir", {31'b0, redirect}, 32'h0); chk("nt_pc", fetch_pc, 32'hF4);
    step(); ex_valid = 1'b0;
    @(negedge clk); chk("nt_next", fetch_pc, 32'hF8);

    // jalr: bit 0 cleared gives an aligned target; bit 1 set halts.
    step(); ctl(1'b1, 2'd2, 32'h200, 32'h3, 32'h2001, 1'b0);
    @(negedge clk); chk("jalr_redir", {31'b0, redirect}, 32'h1);
    step(); ex_valid = 1'b0;
    @(negedge clk); chk("jalr_tgt", fetch_pc, 32'h2004);
    step(); ctl(1'b1, 2'd2, 32'h200, 32'h4, 32'h2003, 1'b0);
    @(negedge clk); chk("mis_redir", {31'b0, redirect}, 32'h1);
    step(); ex_valid = 1'b0;
    @(negedge clk); chk("mis_flag", {31'b0, misalign}, 32'h1);
    chk("mis_addr", misalign_addr, 32'h2006); chk("halt_fv", {31'b0, fetch_valid}, 32'h0);
    step(); ctl(1'b1, 2'd1, 32'h0, 32'h40, 32'h0, 1'b0);
    @(negedge clk); chk("halt_ign", {31'b0, redirect}, 32'h0);
    step(); ex_valid = 1'b0; rst_n = 1'b0;
    step(); rst_n = 1'b1;
    @(negedge clk); @(negedge clk); chk("rst2_pc", fetch_pc, 32'h0);

    // Redirect to 0x40, then a jal while 0x40 is held by memory.
    step(); ctl(1'b1, 2'd1, 32'h0, 32'h40, 32'h0, 1'b0);
    @(negedge clk); chk("j40_redir", {31'b0, redirect}, 32'h1);
    step(); fetch_ready = 1'b0; ctl(1'b1, 2'd1, 32'h300, 32'h500, 32'h0, 1'b0);
    @(negedge clk); chk("hold_pc0", fetch_pc, 32'h40); chk("hold_redir", {31'b0, redirect}, 32'h1);
    step(); ctl(1'b1, 2'd1, 32'h400, 32'h500, 32'h0, 1'b0);
    @(negedge clk); chk("hold_ign", {31'b0, redirect}, 32'h0); chk("hold_pc1", fetch_pc, 32'h40);
    step(); ex_valid = 1'b0;
    @(negedge clk); chk("hold_pc2", fetch_pc, 32'h40); chk("hold_fv", {31'b0, fetch_valid}, 32'h1);
    step(); fetch_ready = 1'b1;
    @(negedge clk); chk("hold_drop", {31'b0, fetch_drop}, 32'h1);
    step();
    @(negedge clk); chk("hold_tgt", fetch_pc, 32'h800); chk("hold_drop0", {31'b0, fetch_drop}, 32'h0);

    // Stall arriving while a request is outstanding.
    step(); fetch_ready = 1'b0;
    @(negedge clk); chk("st_pc0", fetch_pc, 32'h804);
    step(); stall = 1'b1;
    @(negedge clk); chk("st_fv_keep", {31'b0, fetch_valid}, 32'h1); chk("st_pc1", fetch_pc, 32'h804);
    step(); fetch_ready = 1'b1;
    @(negedge clk); chk("st_acc_fv", {31'b0, fetch_valid}, 32'h1);
    step();
    @(negedge clk); chk("st_fv_off", {31'b0, fetch_valid}, 32'h0); chk("st_pc2", fetch_pc, 32'h808);
    step(); stall = 1'b0;
    @(negedge clk); chk("st_resume", fetch_pc, 32'h808);

    // Misaligned jal while a request is outstanding: drain, then halt.
    step(); fetch_ready = 1'b0; ctl(1'b1, 2'd1, 32'h10, 32'h2, 32'h0, 1'b0);
    @(negedge clk); chk("dr_redir", {31'b0, redirect}, 32'h1);
    step(); ex_valid = 1'b0;
    @(negedge clk); chk("dr_pc", fetch_pc, 32'h80C); chk("dr_fv", {31'b0, fetch_valid}, 32'h1);
    step(); fetch_ready = 1'b1;
    @(negedge clk); chk("dr_drop", {31'b0, fetch_drop}, 32'h1);
    step();
    @(negedge clk); chk("dr_halt", {31'b0, fetch_valid}, 32'h0); chk("dr_addr", misalign_addr, 32'h12);
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    @(negedge clk); @(negedge clk); chk("rst3_pc", fetch_pc, 32'h0);

    // Asynchronous reset in the middle of a hold.
    step(); fetch_ready = 1'b0; ctl(1'b1, 2'd1, 32'h0, 32'h100, 32'h0, 1'b0);
    @(negedge clk); chk("ar_redir", {31'b0, redirect}, 32'h1);
    step(); ex_valid = 1'b0;
    @(negedge clk); chk("ar_hold_pc", fetch_pc, 32'h4);
    #2 rst_n = 1'b0;
    #1 chk("ar_fv", {31'b0, fetch_valid}, 32'h0); chk("ar_pc", fetch_pc, 32'h0);
    step(); rst_n = 1'b1; fetch_ready = 1'b1;
    @(negedge clk); chk("ar_idle", {31'b0, fetch_valid}, 32'h0);
    @(negedge clk); chk("ar_pc0", fetch_pc, 32'h0);
    @(negedge clk); chk("ar_pc1", fetch_pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
